// File: rtl/dma_pkg.sv
// Shared types and default geometry for the UART <-> RAM burst DMA.
package dma_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RX_REQ,
        RX_POP,
        RX_WR,
        TX_REQ,
        TX_RD,
        TX_CAP,
        TX_SEND,
        REL
    } dma_state_t;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_RX_BASE  = 'h00;
    localparam int DEF_RX_DEPTH = 16;
    localparam int DEF_TX_BASE  = 'h80;
    localparam int DEF_LEN_W    = 8;
    localparam int DEF_RX_BURST = 4;

endpackage

// File: rtl/dma_ring_ptr.sv
// RX ring write pointer: increments on inc_i and wraps modulo DEPTH (a power of 2).
// Updates one cycle after inc_i; no backpressure.
module dma_ring_ptr #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     inc_i,
    output logic [$clog2(DEPTH)-1:0] ptr_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    // Power-of-2 depth lets the natural overflow implement the ring wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/dma_burst.sv
// Burst DMA: UART RX bytes into a RAM ring, programmable RAM block out to UART TX.
// RX byte reaches RAM 2 cycles after grant; TX read to TX_Valid 2 cycles; stalls on grant/TX_Ready.
module dma_burst
    import dma_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RX_BASE  = DEF_RX_BASE,
    parameter int RX_DEPTH = DEF_RX_DEPTH,
    parameter int TX_BASE  = DEF_TX_BASE,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int RX_BURST = DEF_RX_BURST
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic [DATA_W-1:0]           RX_Data,
    input  logic                        RX_Empty,
    input  logic                        RX_Full,
    output logic                        Data_Read,
    output logic [DATA_W-1:0]           TX_Data,
    output logic                        TX_Valid,
    input  logic                        TX_Ready,
    input  logic [DATA_W-1:0]           DataIn,
    output logic [DATA_W-1:0]           DataOut,
    output logic [ADDR_W-1:0]           Address,
    output logic                        Cs,
    output logic                        Wen,
    output logic                        Oen,
    output logic                        Bus_req,
    input  logic                        Bus_grant,
    input  logic                        Dma_Tx_Start,
    input  logic [LEN_W-1:0]            Tx_Len,
    output logic                        Dma_Tx_Ready,
    output logic [$clog2(RX_DEPTH)-1:0] Rx_Wr_Ptr
);

    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam int BC_W  = $clog2(RX_BURST + 1);

    dma_state_t        state_q, state_d;
    logic [DATA_W-1:0] rx_byte_q, rx_byte_d;
    logic [DATA_W-1:0] tx_dat_q, tx_dat_d;
    logic [LEN_W-1:0]  tx_len_q, tx_len_d;
    logic [LEN_W-1:0]  tx_idx_q, tx_idx_d;
    logic              tx_pend_q, tx_pend_d;
    logic              tx_rdy_q, tx_rdy_d;
    logic [BC_W-1:0]   burst_q, burst_d;
    logic              ptr_inc;
    logic [PTR_W-1:0]  wr_ptr;
    logic              tx_accept;
    logic              tx_last;
    logic              burst_more;
    logic              unused_rx_full;

    assign unused_rx_full = RX_Full;

    assign tx_accept  = Dma_Tx_Start && tx_rdy_q && (Tx_Len != '0);
    assign tx_last    = (tx_idx_q + LEN_W'(1)) == tx_len_q;
    assign burst_more = (burst_q + BC_W'(1)) < BC_W'(RX_BURST);

    dma_ring_ptr #(
        .DEPTH (RX_DEPTH)
    ) u_ring_ptr (
        .clk_i  (Clk),
        .rst_ni (Rst_n),
        .inc_i  (ptr_inc),
        .ptr_o  (wr_ptr)
    );

    always_comb begin
        state_d   = state_q;
        rx_byte_d = rx_byte_q;
        tx_dat_d  = tx_dat_q;
        tx_len_d  = tx_len_q;
        tx_idx_d  = tx_idx_q;
        tx_pend_d = tx_pend_q;
        tx_rdy_d  = tx_rdy_q;
        burst_d   = burst_q;
        ptr_inc   = 1'b0;
        Data_Read = 1'b0;
        Cs        = 1'b0;
        Wen       = 1'b0;
        Oen       = 1'b0;
        Bus_req   = 1'b0;
        TX_Valid  = 1'b0;
        Address   = '0;
        DataOut   = '0;

        if (tx_accept) begin
            tx_len_d  = Tx_Len;
            tx_idx_d  = '0;
            tx_pend_d = 1'b1;
            tx_rdy_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (tx_pend_q) begin
                    state_d = TX_REQ;
                end else if (!RX_Empty) begin
                    state_d = RX_REQ;
                end
            end
            RX_REQ: begin
                Bus_req = 1'b1;
                burst_d = '0;
                if (Bus_grant) begin
                    state_d = RX_POP;
                end
            end
            RX_POP: begin
                Bus_req = 1'b1;
                if (Bus_grant) begin
                    if (RX_Empty) begin
                        state_d = REL;
                    end else begin
                        Data_Read = 1'b1;
                        rx_byte_d = RX_Data;
                        state_d   = RX_WR;
                    end
                end
            end
            RX_WR: begin
                // A captured byte is held here until the bus comes back.
                Bus_req = 1'b1;
                Address = ADDR_W'(RX_BASE) + ADDR_W'(wr_ptr);
                DataOut = rx_byte_q;
                if (Bus_grant) begin
                    Cs      = 1'b1;
                    Wen     = 1'b1;
                    ptr_inc = 1'b1;
                    burst_d = burst_q + BC_W'(1);
                    state_d = (!RX_Empty && burst_more) ? RX_POP : REL;
                end
            end
            TX_REQ: begin
                Bus_req = 1'b1;
                if (Bus_grant) begin
                    state_d = TX_RD;
                end
            end
            TX_RD: begin
                Bus_req = 1'b1;
                Address = ADDR_W'(TX_BASE) + ADDR_W'(tx_idx_q);
                if (Bus_grant) begin
                    Cs      = 1'b1;
                    Oen     = 1'b1;
                    state_d = TX_CAP;
                end
            end
            TX_CAP: begin
                Bus_req  = 1'b1;
                tx_dat_d = DataIn;
                state_d  = TX_SEND;
            end
            TX_SEND: begin
                Bus_req  = 1'b1;
                TX_Valid = 1'b1;
                if (TX_Ready) begin
                    if (tx_last) begin
                        tx_pend_d = 1'b0;
                        tx_rdy_d  = 1'b1;
                        state_d   = REL;
                    end else begin
                        tx_idx_d = tx_idx_q + LEN_W'(1);
                        state_d  = TX_RD;
                    end
                end
            end
            REL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            rx_byte_q <= '0;
            tx_dat_q  <= '0;
            tx_len_q  <= '0;
            tx_idx_q  <= '0;
            tx_pend_q <= 1'b0;
            tx_rdy_q  <= 1'b1;
            burst_q   <= '0;
        end else begin
            state_q   <= state_d;
            rx_byte_q <= rx_byte_d;
            tx_dat_q  <= tx_dat_d;
            tx_len_q  <= tx_len_d;
            tx_idx_q  <= tx_idx_d;
            tx_pend_q <= tx_pend_d;
            tx_rdy_q  <= tx_rdy_d;
            burst_q   <= burst_d;
        end
    end

    assign TX_Data      = tx_dat_q;
    assign Dma_Tx_Ready = tx_rdy_q;
    assign Rx_Wr_Ptr    = wr_ptr;

endmodule
